// File: rtl/move_scan_ctrl.sv
// Checkers move-generation scanner: walks the four diagonal directions and emits, per direction,
// the set of own pieces with a simple move and the set with a capture, via a valid/ready record stream.
module move_scan_ctrl (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] own,
  input  logic [31:0] opp,
  input  logic [31:0] kings,
  input  logic        side,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_dir,
  output logic [31:0] out_move,
  output logic [31:0] out_jump,
  output logic        done,
  output logic        any_jump
);

  typedef enum logic [2:0] {IDLE, SH1, SH2, EMIT, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] own_r, opp_r, kings_r;
  logic        side_r;
  logic [1:0]  dir_r;
  logic [31:0] n_occ_r, n_nopp_r;
  logic [31:0] move_r, jump_r;
  logic        any_jump_r;

  logic [1:0]  first_dir, next_dir;
  logic        has_next;
  logic [31:0] shift_a_in, shift_a, shift_b, movers;

  // Neighbour map: bit i takes x at the square adjacent to i in direction d, 1 when off-board.
  // Even rows sit on columns 0,2,4,6 and odd rows on columns 1,3,5,7.
  function automatic logic [31:0] nbr(input logic [31:0] x, input logic [1:0] d);
    logic [31:0] res;
    int          r, k, j;
    logic        odd, valid;
    res = '1;
    for (int i = 0; i < 32; i++) begin
      r     = i >> 2;
      k     = i & 3;
      odd   = (r % 2) == 1;
      valid = 1'b0;
      j     = 0;
      case (d)
        2'd0: begin valid = (r > 0) && (odd || k > 0); j = odd ? i - 4 : i - 5; end
        2'd1: begin valid = (r > 0) && (!odd || k < 3); j = odd ? i - 3 : i - 4; end
        2'd2: begin valid = (r < 7) && (odd || k > 0); j = odd ? i + 4 : i + 3; end
        default: begin valid = (r < 7) && (!odd || k < 3); j = odd ? i + 5 : i + 4; end
      endcase
      if (valid) res[i] = x[j[4:0]];
    end
    return res;
  endfunction

  // Men of side 0 move up (codes 0,1), side 1 down (codes 2,3); kings make every direction live.
  function automatic logic dir_active(input logic [1:0] d, input logic s, input logic has_kings);
    return (d[1] == s) || has_kings;
  endfunction

  always_comb begin
    first_dir = 2'd0;
    for (int d = 3; d >= 0; d--) begin
      if (dir_active(2'(d), side, |(own & kings))) first_dir = 2'(d);
    end
  end

  always_comb begin
    has_next = 1'b0;
    next_dir = dir_r;
    for (int d = 3; d >= 0; d--) begin
      if (d > int'(dir_r) && dir_active(2'(d), side_r, |(own_r & kings_r))) begin
        has_next = 1'b1;
        next_dir = 2'(d);
      end
    end
  end

  // One shifter serves both levels: occupancy in SH1, the registered first-level map in SH2.
  assign shift_a_in = (state == SH2) ? n_occ_r : (own_r | opp_r);
  assign shift_a    = nbr(shift_a_in, dir_r);
  assign shift_b    = nbr(~opp_r, dir_r);
  assign movers     = (dir_r[1] == side_r) ? own_r : (own_r & kings_r);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = SH1;
      SH1:  state_next = SH2;
      SH2:  state_next = EMIT;
      EMIT: if (out_ready) state_next = has_next ? SH1 : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      own_r      <= '0;
      opp_r      <= '0;
      kings_r    <= '0;
      side_r     <= 1'b0;
      dir_r      <= 2'd0;
      n_occ_r    <= '0;
      n_nopp_r   <= '0;
      move_r     <= '0;
      jump_r     <= '0;
      any_jump_r <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            own_r      <= own;
            opp_r      <= opp;
            kings_r    <= kings;
            side_r     <= side;
            dir_r      <= first_dir;
            any_jump_r <= 1'b0;
          end
        end
        SH1: begin
          n_occ_r  <= shift_a;
          n_nopp_r <= shift_b;
        end
        SH2: begin
          move_r <= movers & ~n_occ_r;
          jump_r <= movers & ~n_nopp_r & ~shift_a;
        end
        EMIT: begin
          if (out_ready) begin
            any_jump_r <= any_jump_r | (|jump_r);
            if (has_next) dir_r <= next_dir;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == EMIT);
  assign done      = (state == DONE);
  assign out_dir   = dir_r;
  assign out_move  = move_r;
  assign out_jump  = jump_r;
  assign any_jump  = any_jump_r;

endmodule

// File: tb/tb_move_scan_ctrl.sv
// Randomized bench for move_scan_ctrl: a board-coordinate model predicts every record and the
// cycle schedule of each scan, and the DUT is compared on every falling edge.
module tb_move_scan_ctrl;

  logic        clock = 1'b0;
  logic        reset_n, start, side, out_ready;
  logic [31:0] own, opp, kings;
  logic        busy, out_valid, done, any_jump;
  logic [1:0]  out_dir;
  logic [31:0] out_move, out_jump;

  int checks = 0;
  int errors = 0;

  int          m_n;
  logic [1:0]  m_dir  [4];
  logic [31:0] m_move [4];
  logic [31:0] m_jump [4];
  logic        m_any;

  always #5 clock = ~clock;

  move_scan_ctrl dut (
    .clock(clock), .reset_n(reset_n), .start(start), .own(own), .opp(opp), .kings(kings),
    .side(side), .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_dir(out_dir),
    .out_move(out_move), .out_jump(out_jump), .done(done), .any_jump(any_jump)
  );

  // Square index -> (row, column) on the 8x8 board, step one diagonal, back to an index; -1 off-board.
  function automatic int nb(input int sq, input int d);
    int r, c, nr, nc;
    r  = sq / 4;
    c  = 2 * (sq % 4) + (r % 2);
    nr = r + ((d < 2) ? -1 : 1);
    nc = c + ((d % 2 == 0) ? -1 : 1);
    if (nr < 0 || nr > 7 || nc < 0 || nc > 7) return -1;
    return nr * 4 + nc / 2;
  endfunction

  task automatic build_model(input logic [31:0] o, input logic [31:0] p, input logic [31:0] k,
                             input logic s);
    logic [31:0] occ, mv, mov, jmp;
    logic        allowed;
    int          a, b;
    m_n   = 0;
    m_any = 1'b0;
    occ   = o | p;
    for (int d = 0; d < 4; d++) begin
      allowed = s ? (d >= 2) : (d < 2);
      if (allowed || (o & k) != 0) begin
        mv  = allowed ? o : (o & k);
        mov = '0;
        jmp = '0;
        for (int i = 0; i < 32; i++) begin
          if (mv[i]) begin
            a = nb(i, d);
            if (a >= 0) begin
              if (!occ[a]) mov[i] = 1'b1;
              b = nb(a, d);
              if (b >= 0 && p[a] && !occ[b]) jmp[i] = 1'b1;
            end
          end
        end
        m_dir[m_n]  = 2'(d);
        m_move[m_n] = mov;
        m_jump[m_n] = jmp;
        m_any       = m_any | (|jmp);
        m_n++;
      end
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_output({tag, " busy"}, 32'(busy), 0);
    check_output({tag, " out_valid"}, 32'(out_valid), 0);
    check_output({tag, " out_dir"}, 32'(out_dir), 0);
    check_output({tag, " out_move"}, out_move, 0);
    check_output({tag, " out_jump"}, out_jump, 0);
    check_output({tag, " done"}, 32'(done), 0);
    check_output({tag, " any_jump"}, 32'(any_jump), 0);
  endtask

  // Hand-computed expectations that pin the model to the board geometry.
  task automatic pin_model;
    build_model(32'h0020_0000, 32'h0, 32'h0, 1'b0);
    check_output("pin V1 count", 32'(m_n), 2);
    check_output("pin V1 dir1", 32'(m_dir[1]), 1);
    check_output("pin V1 move0", m_move[0], 32'h0020_0000);
    check_output("pin V1 move1", m_move[1], 32'h0020_0000);
    check_output("pin V1 jump0", m_jump[0], 32'h0);
    build_model(32'h0020_0000, 32'h0002_0000, 32'h0, 1'b0);
    check_output("pin V2 move0", m_move[0], 32'h0);
    check_output("pin V2 jump0", m_jump[0], 32'h0020_0000);
    check_output("pin V2 move1", m_move[1], 32'h0020_0000);
    check_output("pin V2 any", 32'(m_any), 1);
    build_model(32'h0000_0001, 32'h0, 32'h0, 1'b0);
    check_output("pin V3 count", 32'(m_n), 2);
    check_output("pin V3 move0", m_move[0] | m_move[1], 32'h0);
    build_model(32'h0020_0000, 32'h0, 32'h0020_0000, 1'b0);
    check_output("pin V4 count", 32'(m_n), 4);
    check_output("pin V4 dir3", 32'(m_dir[3]), 3);
    check_output("pin V4 move3", m_move[3], 32'h0020_0000);
  endtask

  // Drive one scan and compare the DUT on every falling edge against the model's schedule:
  // two shift cycles per record, then EMIT held for the chosen stall, then DONE and IDLE.
  task automatic apply_stimulus(input logic [31:0] o, input logic [31:0] p, input logic [31:0] k,
                                input logic s, input int stall0, input bit release_rst);
    int stalls;
    build_model(o, p, k, s);
    @(negedge clock);
    if (release_rst) reset_n = 1'b1;
    own = o; opp = p; kings = k; side = s;
    start = 1'b1;
    out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    own = $urandom; opp = $urandom; kings = $urandom; side = 1'($urandom);
    for (int r = 0; r < m_n; r++) begin
      check_output($sformatf("rec%0d sh1 busy", r), 32'(busy), 1);
      check_output($sformatf("rec%0d sh1 out_valid", r), 32'(out_valid), 0);
      check_output($sformatf("rec%0d sh1 done", r), 32'(done), 0);
      start = 1'($urandom_range(0, 1));
      @(negedge clock);
      check_output($sformatf("rec%0d sh2 busy", r), 32'(busy), 1);
      check_output($sformatf("rec%0d sh2 out_valid", r), 32'(out_valid), 0);
      start = 1'($urandom_range(0, 1));
      @(negedge clock);
      stalls = (stall0 >= 0) ? ((r == 0) ? stall0 : 0) : int'($urandom_range(0, 3));
      for (int st = 0; st <= stalls; st++) begin
        check_output($sformatf("rec%0d emit out_valid", r), 32'(out_valid), 1);
        check_output($sformatf("rec%0d emit busy", r), 32'(busy), 1);
        check_output($sformatf("rec%0d emit done", r), 32'(done), 0);
        check_output($sformatf("rec%0d out_dir", r), 32'(out_dir), 32'(m_dir[r]));
        check_output($sformatf("rec%0d out_move", r), out_move, m_move[r]);
        check_output($sformatf("rec%0d out_jump", r), out_jump, m_jump[r]);
        out_ready = (st == stalls);
        start = 1'($urandom_range(0, 1));
        @(negedge clock);
      end
      out_ready = 1'b0;
      start = 1'b0;
    end
    check_output("done pulse", 32'(done), 1);
    check_output("done busy", 32'(busy), 1);
    check_output("done out_valid", 32'(out_valid), 0);
    check_output("done any_jump", 32'(any_jump), 32'(m_any));
    @(negedge clock);
    check_output("after done pulse", 32'(done), 0);
    check_output("after done busy", 32'(busy), 0);
    check_output("after done any_jump hold", 32'(any_jump), 32'(m_any));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    own = '0; opp = '0; kings = '0; side = 1'b0;
    pin_model();
    repeat (2) @(negedge clock);
    check_idle_zero("reset");

    apply_stimulus(32'h0020_0000, 32'h0, 32'h0, 1'b0, 0, 1'b1);
    apply_stimulus(32'h0020_0000, 32'h0002_0000, 32'h0, 1'b0, 0, 1'b0);
    apply_stimulus(32'h0000_0001, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    apply_stimulus(32'h0020_0000, 32'h0, 32'h0020_0000, 1'b0, 0, 1'b0);
    apply_stimulus(32'h0020_0000, 32'h0, 32'h0, 1'b0, 5, 1'b0);
    apply_stimulus(32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);

    // Reset asserted during the second shift cycle of direction 1.
    build_model(32'h0020_0000, 32'h0, 32'h0, 1'b0);
    @(negedge clock);
    own = 32'h0020_0000; opp = '0; kings = '0; side = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_output("v6 emit dir0 valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    @(negedge clock);
    check_output("v6 sh2 busy", 32'(busy), 1);
    reset_n = 1'b0;
    @(negedge clock);
    check_idle_zero("v6 reset");
    apply_stimulus(32'h0020_0000, 32'h0, 32'h0, 1'b0, 0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] o, p, k;
      o = $urandom & $urandom;
      p = (n % 4 == 0) ? $urandom : ($urandom & ~o);
      k = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
      apply_stimulus(o, p, k, 1'($urandom), -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
